hash_ctrl: RTL

HASH_CTRL -- requirements
Module: hash_ctrl

---
 rtl/hash_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/hash_ctrl.sv
// Block-sequencing controller for an iterated hash core: accepts message blocks,
// runs ROUNDS compression rounds, accumulates, then streams OUT_WORDS digest words.
// Optional abort input enabled by defining HASH_CTRL_ABORT_EN.
module hash_ctrl #(
  parameter int ROUNDS    = 64,
  parameter int OUT_WORDS = 8,
  localparam int RW = $clog2(ROUNDS),
  localparam int OW = $clog2(OUT_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          first_block,
  input  logic          last_block,
  input  logic          blk_valid,
  output logic          blk_ready,
  output logic          iv_load,
  output logic          inner_busy,
  output logic [RW-1:0] round_idx,
  output logic          acc_en,
  output logic          output_enable,
  output logic [OW-1:0] out_idx,
  output logic          busy,
  output logic          done
`ifdef HASH_CTRL_ABORT_EN
  ,
  input  logic          abort
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BLK,
    ROUND,
    ACC,
    OUT
  } state_e;

  localparam logic [RW-1:0] ROUND_LAST = RW'(ROUNDS - 1);
  localparam logic [OW-1:0] OUT_LAST   = OW'(OUT_WORDS - 1);

  state_e        state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic [OW-1:0] out_q, out_d;
  logic          last_q, last_d;
  logic          accept;
  logic          abort_hit;

`ifdef HASH_CTRL_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign blk_ready = (state_q == IDLE) || (state_q == WAIT_BLK);
  assign accept    = blk_valid && blk_ready;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    out_d   = out_q;
    last_d  = last_q;

    unique case (state_q)
      IDLE: begin
        // A non-first block while idle is consumed and dropped.
        if (accept && first_block) begin
          state_d = ROUND;
          round_d = '0;
          last_d  = last_block;
        end
      end
      WAIT_BLK: begin
        if (accept) begin
          state_d = ROUND;
          round_d = '0;
          last_d  = last_block;
        end
      end
      ROUND: begin
        if (round_q == ROUND_LAST) begin
          state_d = ACC;
          round_d = '0;
        end else begin
          round_d = round_q + RW'(1);
        end
      end
      ACC: begin
        state_d = last_q ? OUT : WAIT_BLK;
        out_d   = '0;
      end
      OUT: begin
        if (out_q == OUT_LAST) begin
          state_d = IDLE;
          out_d   = '0;
          last_d  = 1'b0;
        end else begin
          out_d = out_q + OW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        round_d = '0;
        out_d   = '0;
        last_d  = 1'b0;
      end
    endcase

    if (abort_hit) begin
      state_d = IDLE;
      round_d = '0;
      out_d   = '0;
      last_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      round_q <= '0;
      out_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      out_q   <= out_d;
      last_q  <= last_d;
    end
  end

  // Abort suppresses the accept side effects and the accumulate/done strobes.
  assign iv_load       = accept && first_block && !abort_hit;
  assign inner_busy    = (state_q == ROUND);
  assign round_idx     = round_q;
  assign acc_en        = (state_q == ACC) && !abort_hit;
  assign output_enable = (state_q == OUT);
  assign out_idx       = out_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == OUT) && (out_q == OUT_LAST) && !abort_hit;

endmodule
